// File: rtl/ifetch_unit_pkg.sv
// Shared definitions for the instruction-fetch unit: FSM encoding,
// ISA width defaults and the default reset/halt vectors.
package ifetch_unit_pkg;

  typedef enum logic [1:0] {
    ST_RUN        = 2'd0,
    ST_IO_WAIT    = 2'd1,
    ST_IO_RELEASE = 2'd2,
    ST_HALT       = 2'd3
  } fetch_state_e;

  localparam int unsigned ISA_XLEN        = 32;
  localparam int unsigned ISA_JADDR_WIDTH = 26;
  localparam int unsigned ISA_IMEM_AW     = 14;

  localparam logic [31:0] DEFAULT_RESET_PC        = 32'h0000_0000;
  localparam logic [31:0] DEFAULT_HALT_PC         = 32'h1111_1100;
  localparam int unsigned DEFAULT_DEBOUNCE_CYCLES = 16;

endpackage

// File: rtl/ifetch_unit_btn_debounce.sv
// Confirm-button conditioner: 2-flop synchroniser, stability counter, debounced
// level and a one-cycle rise pulse that is only issued once the button was seen released.
module ifetch_unit_btn_debounce #(
  parameter int unsigned DEBOUNCE_CYCLES = 16
) (
  input  logic clock,
  input  logic reset_n,
  input  logic button,
  output logic level,
  output logic rise
);

  localparam int unsigned CW = $clog2(DEBOUNCE_CYCLES + 1);
  localparam logic [CW-1:0] CNT_LAST = CW'(DEBOUNCE_CYCLES - 1);
  localparam logic [CW-1:0] CNT_ONE  = CW'(1);

  logic          sync1_r;
  logic          sync2_r;
  logic          level_r;
  logic          rise_r;
  logic          armed_r;
  logic [CW-1:0] cnt_r;

  logic differ_s;
  logic arming_s;
  logic counting_s;
  logic expire_s;

  // Classify the current cycle: level change pending, or arming on a stable release.
  always_comb begin
    differ_s   = (sync2_r != level_r);
    arming_s   = !armed_r && !sync2_r && !level_r;
    counting_s = differ_s || arming_s;
    expire_s   = counting_s && (cnt_r == CNT_LAST);
  end

  // Two-flop synchroniser for the asynchronous button.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      sync1_r <= 1'b0;
      sync2_r <= 1'b0;
    end else begin
      sync1_r <= button;
      sync2_r <= sync1_r;
    end
  end

  // Stability counter, debounced level and qualified rise pulse.
  // A button held through reset must be released (and seen released) before a rise counts.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      cnt_r   <= {CW{1'b0}};
      level_r <= 1'b0;
      rise_r  <= 1'b0;
      armed_r <= 1'b0;
    end else begin
      rise_r <= 1'b0;
      if (!counting_s) begin
        cnt_r <= {CW{1'b0}};
      end else if (expire_s) begin
        cnt_r <= {CW{1'b0}};
        if (arming_s) begin
          armed_r <= 1'b1;
        end else begin
          level_r <= sync2_r;
          rise_r  <= sync2_r & armed_r;
        end
      end else begin
        cnt_r <= cnt_r + CNT_ONE;
      end
    end
  end

  assign level = level_r;
  assign rise  = rise_r;

endmodule

// File: rtl/ifetch_unit.sv
// Instruction-fetch unit: PC register (falling edge), next-PC selection,
// console-input wait FSM with debounced confirm, and halt parking.
module ifetch_unit
  import ifetch_unit_pkg::*;
#(
  parameter int unsigned XLEN            = ISA_XLEN,
  parameter int unsigned JADDR_WIDTH     = ISA_JADDR_WIDTH,
  parameter int unsigned IMEM_AW         = ISA_IMEM_AW,
  parameter logic [XLEN-1:0] RESET_PC    = XLEN'(DEFAULT_RESET_PC),
  parameter logic [XLEN-1:0] HALT_PC     = XLEN'(DEFAULT_HALT_PC),
  parameter int unsigned DEBOUNCE_CYCLES = DEFAULT_DEBOUNCE_CYCLES
) (
  input  logic               clock,
  input  logic               reset_n,
  input  logic               io_read,
  input  logic [XLEN-1:0]    addr_result,
  input  logic [XLEN-1:0]    read_data_1,
  input  logic               branch,
  input  logic               nbranch,
  input  logic               jmp,
  input  logic               jal,
  input  logic               jr,
  input  logic               zero,
  input  logic               confirm_button,
  input  logic [XLEN-1:0]    imem_rdata,
  output logic [IMEM_AW-1:0] imem_addr,
  output logic [XLEN-1:0]    instruction,
  output logic [XLEN-1:0]    pc,
  output logic [XLEN-1:0]    branch_base_addr,
  output logic [XLEN-1:0]    link_addr,
  output logic               io_waiting,
  output logic               halted
);

  localparam logic [XLEN-1:0] PC_STEP = XLEN'(32'd4);

  fetch_state_e    state_r;
  fetch_state_e    state_nxt_s;
  logic [XLEN-1:0] pc_r;
  logic [XLEN-1:0] pc_nxt_s;
  logic [XLEN-1:0] pc_plus4_s;
  logic [XLEN-1:0] jump_target_s;
  logic [XLEN-1:0] flow_next_s;
  logic [XLEN-1:0] instruction_s;
  logic            jump_s;
  logic            take_branch_s;
  logic            io_stall_s;
  logic            db_level_s;
  logic            db_rise_s;
  logic            io_waiting_r;
  logic            halted_r;

  ifetch_unit_btn_debounce #(
    .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES)
  ) u_btn_debounce (
    .clock   (clock),
    .reset_n (reset_n),
    .button  (confirm_button),
    .level   (db_level_s),
    .rise    (db_rise_s)
  );

  // Instruction is forced to zero the moment reset asserts, independent of the ROM.
  always_comb begin
    if (reset_n) begin
      instruction_s = imem_rdata;
    end else begin
      instruction_s = {XLEN{1'b0}};
    end
  end

  // Next-PC candidate: jump, then taken branch, then jr, else sequential.
  always_comb begin
    pc_plus4_s    = pc_r + PC_STEP;
    jump_target_s = {pc_r[XLEN-1:JADDR_WIDTH+2], instruction_s[JADDR_WIDTH-1:0], 2'b00};
    jump_s        = jmp | jal;
    take_branch_s = (branch & zero) | (nbranch & ~zero);
    io_stall_s    = io_read & ~jump_s;
    if (jump_s) begin
      flow_next_s = jump_target_s;
    end else if (take_branch_s) begin
      flow_next_s = addr_result;
    end else if (jr) begin
      flow_next_s = read_data_1;
    end else begin
      flow_next_s = pc_plus4_s;
    end
  end

  // Fetch FSM next-state and PC update.
  always_comb begin
    state_nxt_s = state_r;
    pc_nxt_s    = pc_r;
    case (state_r)
      ST_RUN: begin
        if (pc_r == HALT_PC) begin
          state_nxt_s = ST_HALT;
        end else if (io_stall_s) begin
          state_nxt_s = ST_IO_WAIT;
        end else begin
          pc_nxt_s = flow_next_s;
        end
      end
      ST_IO_WAIT: begin
        if (db_rise_s) begin
          pc_nxt_s    = flow_next_s;
          state_nxt_s = ST_IO_RELEASE;
        end else begin
          state_nxt_s = ST_IO_WAIT;
        end
      end
      ST_IO_RELEASE: begin
        // The press that released IO_WAIT must drop before another io_read may wait on it.
        if (pc_r == HALT_PC) begin
          state_nxt_s = ST_HALT;
        end else begin
          if (io_stall_s) begin
            pc_nxt_s = pc_r;
          end else begin
            pc_nxt_s = flow_next_s;
          end
          if (db_level_s) begin
            state_nxt_s = ST_IO_RELEASE;
          end else begin
            state_nxt_s = ST_RUN;
          end
        end
      end
      ST_HALT: begin
        state_nxt_s = ST_HALT;
      end
      default: begin
        state_nxt_s = ST_RUN;
        pc_nxt_s    = RESET_PC;
      end
    endcase
  end

  // PC, state and status flags update on the falling edge, ahead of the ROM's rising-edge read.
  always_ff @(negedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state_r      <= ST_RUN;
      pc_r         <= RESET_PC;
      io_waiting_r <= 1'b0;
      halted_r     <= 1'b0;
    end else begin
      state_r      <= state_nxt_s;
      pc_r         <= pc_nxt_s;
      io_waiting_r <= (state_nxt_s == ST_IO_WAIT) || (state_nxt_s == ST_IO_RELEASE);
      halted_r     <= (state_nxt_s == ST_HALT);
    end
  end

  assign imem_addr        = pc_r[IMEM_AW+1:2];
  assign instruction      = instruction_s;
  assign pc               = pc_r;
  assign branch_base_addr = pc_plus4_s;
  assign link_addr        = pc_plus4_s;
  assign io_waiting       = io_waiting_r;
  assign halted           = halted_r;

endmodule
